irq_ctl: RTL and testbench

IRQ_CTL -- requirements
Module: irq_ctl

---
 rtl/irq_ctl_pkg.sv | 19 +
 rtl/irq_ctl_if.sv | 21 ++
 rtl/irq_ctl_prio_enc.sv | 35 +++
 rtl/irq_ctl.sv | 193 +++++++++++++++++++
 tb/tb_irq_ctl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_ctl_pkg.sv
// irq_ctl shared constants: FSM encoding, register
// indices and STATUS field positions.
package irq_ctl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SVC  = 2'd2;

  localparam logic [1:0] RG_PEND   = 2'd0;
  localparam logic [1:0] RG_MASK   = 2'd1;
  localparam logic [1:0] RG_STATUS = 2'd2;
  localparam logic [1:0] RG_VBASE  = 2'd3;

  localparam int STAT_ACT_LSB = 0;
  localparam int STAT_ACT_W   = 4;
  localparam int STAT_ST_LSB  = 8;
  localparam int STAT_ST_W    = 2;

endpackage

// File: rtl/irq_ctl_if.sv
// irq_ctl register bus: select, write enable,
// word index, write data and registered read data.
interface irq_ctl_if;

  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output sel, we, addr, wdata,
    input  rdata
  );

  modport slave (
    input  sel, we, addr, wdata,
    output rdata
  );

endinterface

// File: rtl/irq_ctl_prio_enc.sv
// irq_prio_enc: finds the first set request bit,
// searching upward from start and wrapping at NSRC.
module irq_prio_enc #(
  parameter int NSRC = 8
) (
  input  logic [NSRC-1:0] req,
  input  logic [3:0]      start,
  output logic            found,
  output logic [3:0]      idx
);

  logic [2*NSRC-1:0] w_dbl;
  logic [NSRC-1:0]   w_rot;

  assign w_dbl = {req, req};
  assign w_rot = NSRC'(w_dbl >> start);

  // first set bit of the rotated view, mapped back
  always_comb begin
    logic [4:0] w_sum;
    found = 1'b0;
    idx   = 4'd0;
    w_sum = 5'd0;
    for (int k = 0; k < NSRC; k++) begin
      if (!found && w_rot[k]) begin
        found = 1'b1;
        w_sum = {1'b0, start} + 5'(k);
        if (w_sum >= 5'(NSRC))
          w_sum = w_sum - 5'(NSRC);
        idx = w_sum[3:0];
      end
    end
  end

endmodule

// File: rtl/irq_ctl.sv
// irq_ctl: edge-latched interrupt controller with
// vectored request. Option: IRQ_CTL_ROTATE_EN.
import irq_ctl_pkg::*;

module irq_ctl #(
  parameter int         NSRC      = 8,
  parameter logic [30:0] VBASE_RST = 31'h00000100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  irq_ctl_if.slave        bus,
  input  logic [31:0]     ma,
  output logic            irq,
  output logic [30:0]     xadr
);

  logic [NSRC-1:0] r_src_q;
  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_mask;
  logic [28:0]     r_vbase;
  logic [1:0]      r_state;
  logic [3:0]      r_act;
  logic [31:0]     r_rdata;

  logic [NSRC-1:0] w_edge;
  logic [NSRC-1:0] w_act_oh;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_pend_n;
  logic [NSRC-1:0] w_mask_n;
  logic            w_wr;
  logic            w_wr_pend;
  logic            w_wr_mask;
  logic            w_wr_stat;
  logic            w_wr_vb;
  logic            w_eoi;
  logic            w_keep;
  logic            w_hit;
  logic            w_found;
  logic [3:0]      w_idx;
  logic [3:0]      w_start;
  logic [1:0]      w_state_n;
  logic [3:0]      w_act_n;
  logic [31:0]     w_rd;
  logic            w_unused;

  assign w_unused = bus.wdata[31];

  assign w_edge    = src & ~r_src_q;
  assign w_wr      = bus.sel & bus.we;
  assign w_wr_pend = w_wr & (bus.addr == RG_PEND);
  assign w_wr_mask = w_wr & (bus.addr == RG_MASK);
  assign w_wr_stat = w_wr & (bus.addr == RG_STATUS);
  assign w_wr_vb   = w_wr & (bus.addr == RG_VBASE);
  assign w_eoi     = w_wr_stat & (r_state == ST_SVC);

  // one-hot of the active index
  always_comb begin
    w_act_oh = '0;
    for (int i = 0; i < NSRC; i++)
      w_act_oh[i] = (r_act == 4'(i));
  end

  // W1C and EOI clear; a new edge wins
  always_comb begin
    w_clr = '0;
    if (w_wr_pend)
      w_clr = w_clr | bus.wdata[NSRC-1:0];
    if (w_eoi)
      w_clr = w_clr | w_act_oh;
    w_pend_n = (r_pend & ~w_clr) | w_edge;
  end

  assign w_mask_n = w_wr_mask ?
                    bus.wdata[NSRC-1:0] : r_mask;

  // retraction looks at this cycle's writes
  assign w_keep = |(w_pend_n & w_mask_n & w_act_oh);

  assign xadr = {r_vbase, 2'b00} +
                {25'd0, r_act, 2'b00};
  assign w_hit = (ma == {1'b1, xadr});
  assign irq   = (r_state == ST_REQ);

`ifdef IRQ_CTL_ROTATE_EN
  logic [3:0] r_last;

  // last serviced index, updated on EOI
  always_ff @(posedge clk) begin
    if (!reset)
      r_last <= 4'(NSRC - 1);
    else if (w_eoi)
      r_last <= r_act;
  end

  assign w_start = (r_last == 4'(NSRC - 1)) ?
                   4'd0 : r_last + 4'd1;
`else
  assign w_start = 4'd0;
`endif

  irq_prio_enc #(
    .NSRC (NSRC)
  ) u_prio (
    .req   (r_pend & r_mask),
    .start (w_start),
    .found (w_found),
    .idx   (w_idx)
  );

  // request FSM next state and winner latch
  always_comb begin
    w_state_n = r_state;
    w_act_n   = r_act;
    unique case (1'b1)
      (r_state == ST_IDLE): begin
        if (w_found) begin
          w_state_n = ST_REQ;
          w_act_n   = w_idx;
        end
      end
      (r_state == ST_REQ): begin
        if (!w_keep)
          w_state_n = ST_IDLE;
        else if (w_hit)
          w_state_n = ST_SVC;
      end
      (r_state == ST_SVC): begin
        if (w_eoi)
          w_state_n = ST_IDLE;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // register read mux
  always_comb begin
    w_rd = '0;
    unique case (bus.addr)
      RG_PEND: w_rd = 32'(r_pend);
      RG_MASK: w_rd = 32'(r_mask);
      RG_STATUS: begin
        w_rd[STAT_ST_LSB +: STAT_ST_W]   = r_state;
        w_rd[STAT_ACT_LSB +: STAT_ACT_W] = r_act;
      end
      RG_VBASE: w_rd = {1'b0, r_vbase, 2'b00};
      default: w_rd = '0;
    endcase
  end

  // source sampling, pending and mask
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_src_q <= '0;
      r_pend  <= '0;
      r_mask  <= '0;
    end else begin
      r_src_q <= src;
      r_pend  <= w_pend_n;
      r_mask  <= w_mask_n;
    end
  end

  // vector base register
  always_ff @(posedge clk) begin
    if (!reset)
      r_vbase <= VBASE_RST[30:2];
    else if (w_wr_vb)
      r_vbase <= bus.wdata[30:2];
  end

  // FSM state and active index
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_act   <= 4'd0;
    end else begin
      r_state <= w_state_n;
      r_act   <= w_act_n;
    end
  end

  // registered read data, held while unselected
  always_ff @(posedge clk) begin
    if (!reset)
      r_rdata <= '0;
    else if (bus.sel)
      r_rdata <= w_rd;
  end

  assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_irq_ctl.sv
// tb_irq_ctl: randomized scenarios against a queue
// scoreboard; a negedge monitor does all checks.
module tb_irq_ctl;
  import irq_ctl_pkg::*;

  localparam int K_RD   = 0;
  localparam int K_IRQ  = 1;
  localparam int K_XADR = 2;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  src = '0;
  logic [31:0] ma = '0;
  logic        irq;
  logic [30:0] xadr;

  irq_ctl_if bus ();

  irq_ctl #(
    .NSRC      (8),
    .VBASE_RST (31'h00000100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .src   (src),
    .bus   (bus),
    .ma    (ma),
    .irq   (irq),
    .xadr  (xadr)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   m_act = 0;
  exp_t sbq[$];
  exp_t me;
  logic [31:0] mact;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void expect_at(
    input int c, input int k,
    input logic [31:0] v, input string nm);
    exp_t e;
    int   i;
    e.cyc = c; e.kind = k; e.exp = v; e.name = nm;
    i = sbq.size();
    while (i > 0 && sbq[i-1].cyc > c) i--;
    sbq.insert(i, e);
  endfunction

  // monitor: pop every expectation due this cycle
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      me = sbq.pop_front();
      case (me.kind)
        K_IRQ:   mact = {31'd0, irq};
        K_XADR:  mact = {1'b0, xadr};
        default: mact = bus.rdata;
      endcase
      n_tests++;
      if (me.cyc != cyc || mact !== me.exp) begin
        n_fail++;
        $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h",
                 me.name, cyc, me.cyc, mact, me.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [31:0] d);
    bus.sel = 1'b1; bus.we = 1'b1;
    bus.addr = a; bus.wdata = d;
    tick();
    bus.sel = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a,
                    input logic [31:0] v,
                    input string nm);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
    expect_at(cyc + 1, K_RD, v, nm);
    tick();
    bus.sel = 1'b0;
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  // one pulse burst, serviced in priority order
  task automatic scenario(input logic [7:0] m,
                          input logic [7:0] p,
                          input logic [30:0] v,
                          input int rmode);
    logic [7:0]  pend, msk, ph;
    logic [30:0] vexp;
    logic [31:0] sum;
    int          w, t_req, c;
    bit          first;
    vexp = {v[30:2], 2'b00};
    wr(RG_VBASE, {1'b0, v});
    wr(RG_MASK, {24'd0, m});
    rd(RG_VBASE, {1'b0, vexp}, "vbase_rb");
    rd(RG_MASK, {24'd0, m}, "mask_rb");
    pend = p; msk = m; first = 1'b1;
    src = p; c = cyc; tick(); src = '0;
    t_req = c + 2;
    forever begin
      ph = pend & msk;
      expect_at(t_req - 1, K_IRQ, 0, "irq_low");
      if (ph == 0) begin
        expect_at(t_req, K_IRQ, 0, "irq_none");
        break;
      end
      w = lowest(ph);
      m_act = w;
      sum = {1'b0, vexp} + 32'(w * 4);
      expect_at(t_req, K_IRQ, 1, "irq_req");
      expect_at(t_req, K_XADR, {1'b0, sum[30:0]}, "xadr");
      while (cyc < t_req) tick();
      if ((rmode == 1 && first) ||
          (rmode == 2 && $urandom_range(3) == 0)) begin
        msk = msk & ~(8'd1 << w);
        wr(RG_MASK, {24'd0, msk});
        t_req = t_req + 2;
      end else begin
        ma = {1'b1, sum[30:0]};
        tick();
        ma = '0;
        expect_at(t_req + 1, K_IRQ, 0, "irq_svc");
        rd(RG_STATUS, 32'h200 | 32'(w), "status_svc");
        wr(RG_STATUS, $urandom);
        pend = pend & ~(8'd1 << w);
        t_req = t_req + 4;
      end
      first = 1'b0;
    end
    while (cyc < t_req) tick();
    rd(RG_PEND, {24'd0, pend}, "pend_left");
    rd(RG_STATUS, 32'(m_act), "status_idle");
    wr(RG_MASK, 32'd0);
    wr(RG_PEND, 32'hFF);
    rd(RG_PEND, 32'd0, "pend_clr");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [30:0] xe;
    int          c;
    bus.sel = 1'b0; bus.we = 1'b0;
    bus.addr = '0; bus.wdata = '0;
    reset = 1'b0;
    tick(); tick();
    expect_at(cyc, K_IRQ, 0, "rst_irq");
    expect_at(cyc, K_XADR, 32'h100, "rst_xadr");
    expect_at(cyc, K_RD, 32'h0, "rst_rdata");
    tick();
    reset = 1'b1;
    tick();
    rd(RG_PEND, 32'h0, "rst_pend");
    rd(RG_MASK, 32'h0, "rst_mask");
    rd(RG_STATUS, 32'h0, "rst_status");
    rd(RG_VBASE, 32'h100, "rst_vbase");
    expect_at(cyc + 1, K_RD, 32'h100, "rdata_hold");
    tick(); tick();

    scenario(8'h04, 8'h04, 31'h100, 0);
    scenario(8'hFF, 8'h22, 31'h100, 0);
    scenario(8'h01, 8'h01, 31'h200, 1);
    scenario(8'h02, 8'h02, 31'h7FFFFFFC, 0);

    // W1C in the same cycle as a new edge
    src = 8'h08; tick(); src = '0;
    rd(RG_PEND, 32'h08, "pend_set");
    bus.sel = 1'b1; bus.we = 1'b1;
    bus.addr = RG_PEND; bus.wdata = 32'h08;
    src = 8'h08;
    tick();
    bus.sel = 1'b0; bus.we = 1'b0; src = '0;
    rd(RG_PEND, 32'h08, "w1c_race");
    wr(RG_PEND, 32'h08);
    rd(RG_PEND, 32'h0, "w1c_clear");

    for (int it = 0; it < 30; it++)
      scenario(8'($urandom), 8'($urandom),
               31'($urandom), 2);

    // reset while in service
    wr(RG_VBASE, 32'h100);
    wr(RG_MASK, 32'h04);
    src = 8'h04; c = cyc; tick(); src = '0;
    while (cyc < c + 2) tick();
    xe = 31'h108;
    expect_at(cyc, K_IRQ, 1, "pre_rst_req");
    ma = {1'b1, xe}; tick(); ma = '0;
    expect_at(cyc, K_IRQ, 0, "pre_rst_svc");
    reset = 1'b0;
    expect_at(cyc + 1, K_IRQ, 0, "svcrst_irq");
    expect_at(cyc + 1, K_XADR, 32'h100, "svcrst_xadr");
    expect_at(cyc + 1, K_RD, 32'h0, "svcrst_rdata");
    tick();
    reset = 1'b1;
    rd(RG_PEND, 32'h0, "svcrst_pend");
    rd(RG_MASK, 32'h0, "svcrst_mask");
    rd(RG_VBASE, 32'h100, "svcrst_vbase");
    wr(RG_STATUS, 32'hFFFFFFFF);
    rd(RG_STATUS, 32'h0, "stray_eoi");
    rd(RG_PEND, 32'h0, "stray_pend");
    expect_at(cyc, K_IRQ, 0, "stray_irq");

    repeat (4) tick();
    if (sbq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL leftover got=%0d exp=0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
